// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared constants and types for the 4x4 output-stationary systolic
// matrix-multiply job sequencer.
//   ARRAY_SIZE / DW_IN / DW_OUT : default array geometry and data widths
//   FEED_CYC / DRAIN_CYC        : skewed-feed and pipeline-drain lengths
//   STEP_W                      : width of the shared step counter
//   seq_state_e                 : sequencer FSM states
//   operand_t / result_t        : signed element types
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int ARRAY_SIZE = 4;
    localparam int DW_IN      = 8;
    localparam int DW_OUT     = 2 * DW_IN + $clog2(ARRAY_SIZE);

    localparam int FEED_CYC   = 2 * ARRAY_SIZE - 1;
    localparam int DRAIN_CYC  = ARRAY_SIZE;
    localparam int STEP_W     = $clog2(FEED_CYC);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPT,
        RESULT
    } seq_state_e;

    typedef logic signed [DW_IN-1:0]  operand_t;
    typedef logic signed [DW_OUT-1:0] result_t;

    // Step counter width for an array of dimension n (never narrower than 1).
    function automatic int step_width(input int n);
        return ($clog2(2 * n - 1) > 0) ? $clog2(2 * n - 1) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_mux.sv
// ---------------------------------------------------------------------------
// systolic_skew_mux
// Combinational edge-operand selector. At feed step t, west lane i carries
// A[i][t-i] and north lane j carries B[t-j][j]; out-of-range lanes and any
// cycle with feed_en low drive zero, so the array only ever sees the
// diagonal wavefront.
// Ports:
//   feed_en : high during the FEED phase
//   step    : feed step t
//   a_lat   : latched A, A[i][k] at ((i*N+k)*DW_IN)+:DW_IN
//   b_lat   : latched B, B[k][j] same packing
//   arr_a   : west-edge operands, lane i -> row i
//   arr_b   : north-edge operands, lane j -> column j
// ---------------------------------------------------------------------------
module systolic_skew_mux
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
    parameter int DW_IN      = systolic_pkg::DW_IN,
    parameter int CNT_W      = systolic_pkg::STEP_W
) (
    input  logic                                   feed_en,
    input  logic [CNT_W-1:0]                       step,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DW_IN-1:0] a_lat,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DW_IN-1:0] b_lat,
    output logic [ARRAY_SIZE*DW_IN-1:0]            arr_a,
    output logic [ARRAY_SIZE*DW_IN-1:0]            arr_b
);

    always_comb begin
        // NOTE: every output gets a default before the conditional writes,
        // otherwise the untaken paths would infer latches.
        arr_a = '0;
        arr_b = '0;
        for (int lane = 0; lane < ARRAY_SIZE; lane++) begin
            int k;
            k = int'(step) - lane;
            if (feed_en && (k >= 0) && (k < ARRAY_SIZE)) begin
                arr_a[lane*DW_IN +: DW_IN] = a_lat[(lane*ARRAY_SIZE + k)*DW_IN +: DW_IN];
                arr_b[lane*DW_IN +: DW_IN] = b_lat[(k*ARRAY_SIZE + lane)*DW_IN +: DW_IN];
            end
        end
    end

endmodule

// File: rtl/systolic_mm_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_mm_sequencer
// Job controller for an NxN output-stationary systolic matrix-multiply
// array: latches A/B on a start handshake, clears the PE accumulators,
// streams skewed operands, waits out the drain, captures C and holds it
// behind a valid/ready result handshake.
// Flow: IDLE -> CLEAR -> FEED(2N-1) -> DRAIN(N) -> CAPT -> RESULT -> IDLE.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start / start_ready   : job request; start_ready high only in IDLE
//   start_accum           : (SYSTOLIC_SEQ_ACCUM_EN only) skip the clear so
//                           the array accumulates C_prev + A*B
//   a_mat / b_mat         : operand matrices, element (r,c) at ((r*N+c)*DW_IN)
//   arr_rst_n             : active-low PE accumulator clear
//   arr_a / arr_b         : west / north edge operands
//   arr_c                 : PE result bus, packed like a_mat
//   c_mat                 : captured result
//   res_valid / res_ready : result handshake
//   busy                  : high outside IDLE
//   done                  : one-cycle pulse when res_valid rises
// Build option: define SYSTOLIC_SEQ_ACCUM_EN to add the start_accum port.
// ---------------------------------------------------------------------------
module systolic_mm_sequencer
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = systolic_pkg::ARRAY_SIZE,
    parameter int DW_IN      = systolic_pkg::DW_IN,
    parameter int DW_OUT     = 2 * DW_IN + $clog2(ARRAY_SIZE)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
`ifdef SYSTOLIC_SEQ_ACCUM_EN
    input  logic                                    start_accum,
`endif
    output logic                                    start_ready,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DW_IN-1:0]  a_mat,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DW_IN-1:0]  b_mat,
    output logic                                    arr_rst_n,
    output logic [ARRAY_SIZE*DW_IN-1:0]             arr_a,
    output logic [ARRAY_SIZE*DW_IN-1:0]             arr_b,
    input  logic [ARRAY_SIZE*ARRAY_SIZE*DW_OUT-1:0] arr_c,
    output logic [ARRAY_SIZE*ARRAY_SIZE*DW_OUT-1:0] c_mat,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic                                    busy,
    output logic                                    done
);

    localparam int FEED_LEN  = 2 * ARRAY_SIZE - 1;
    localparam int DRAIN_LEN = ARRAY_SIZE;
    localparam int CNT_W     = step_width(ARRAY_SIZE);

    seq_state_e                           state;
    logic [CNT_W-1:0]                     step;
    logic [ARRAY_SIZE*ARRAY_SIZE*DW_IN-1:0] a_lat;
    logic [ARRAY_SIZE*ARRAY_SIZE*DW_IN-1:0] b_lat;
    logic                                 accept;
    logic                                 accum_req;

`ifdef SYSTOLIC_SEQ_ACCUM_EN
    assign accum_req = start_accum;
`else
    assign accum_req = 1'b0;
`endif

    assign accept = start && start_ready;

    // Held low during reset as well, so an aborted job never leaves
    // partial sums in the array.
    assign arr_rst_n = ~rst && (state != CLEAR);

    // NOTE: the operand latches are plain data registers with no reset; they
    // are only ever read after an accept has loaded them, and leaving them off
    // the reset net keeps the wide flops cheap.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_lat <= a_mat;
            b_lat <= b_mat;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            c_mat       <= '0;
            res_valid   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        step        <= '0;
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                        state       <= accum_req ? FEED : CLEAR;
                    end
                end
                CLEAR: begin
                    step  <= '0;
                    state <= FEED;
                end
                FEED: begin
                    if (step == CNT_W'(FEED_LEN - 1)) begin
                        step  <= '0;
                        state <= DRAIN;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DRAIN: begin
                    // The counter is reused to wait for the last product to
                    // ripple through to the far corner PE.
                    if (step == CNT_W'(DRAIN_LEN - 1)) begin
                        step  <= '0;
                        state <= CAPT;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                CAPT: begin
                    c_mat     <= arr_c;
                    res_valid <= 1'b1;
                    done      <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    step        <= '0;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

    systolic_skew_mux #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DW_IN      (DW_IN),
        .CNT_W      (CNT_W)
    ) u_skew_mux (
        .feed_en (state == FEED),
        .step    (step),
        .a_lat   (a_lat),
        .b_lat   (b_lat),
        .arr_a   (arr_a),
        .arr_b   (arr_b)
    );

endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_systolic_mm_sequencer
// Drives the sequencer around a behavioural 4x4 output-stationary PE array
// and checks results against hand-derived matrices.
// Define SYSTOLIC_SEQ_ACCUM_EN to also exercise the accumulate option.
// ---------------------------------------------------------------------------
module tb_systolic_mm_sequencer;

    localparam int N  = 4;
    localparam int DI = 8;
    localparam int DO = 18;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
    logic                start_accum = 1'b0;
`endif
    logic                start_ready;
    logic [N*N*DI-1:0]   a_mat = '0;
    logic [N*N*DI-1:0]   b_mat = '0;
    logic                arr_rst_n;
    logic [N*DI-1:0]     arr_a;
    logic [N*DI-1:0]     arr_b;
    logic [N*N*DO-1:0]   arr_c;
    logic [N*N*DO-1:0]   c_mat;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic                busy;
    logic                done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int accept_log[$];

    always #5 clk = ~clk;

    systolic_mm_sequencer #(
        .ARRAY_SIZE (N),
        .DW_IN      (DI),
        .DW_OUT     (DO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef SYSTOLIC_SEQ_ACCUM_EN
        .start_accum (start_accum),
`endif
        .start_ready (start_ready),
        .a_mat       (a_mat),
        .b_mat       (b_mat),
        .arr_rst_n   (arr_rst_n),
        .arr_a       (arr_a),
        .arr_b       (arr_b),
        .arr_c       (arr_c),
        .c_mat       (c_mat),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .done        (done)
    );

    // ---------------- behavioural PE array ----------------
    logic signed [DI-1:0] a_pipe [N][N];
    logic signed [DI-1:0] b_pipe [N][N];
    logic signed [DO-1:0] acc    [N][N];
    logic signed [DI-1:0] a_in   [N][N];
    logic signed [DI-1:0] b_in   [N][N];
    logic signed [DO-1:0] prod   [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) a_in[i][j] = arr_a[i*DI +: DI];
                else        a_in[i][j] = a_pipe[i][j-1];
                if (i == 0) b_in[i][j] = arr_b[j*DI +: DI];
                else        b_in[i][j] = b_pipe[i-1][j];
                prod[i][j] = DO'(a_in[i][j]) * DO'(b_in[i][j]);
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_c[(i*N + j)*DO +: DO] = acc[i][j];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!arr_rst_n) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end else begin
                    a_pipe[i][j] <= a_in[i][j];
                    b_pipe[i][j] <= b_in[i][j];
                    acc[i][j]    <= acc[i][j] + prod[i][j];
                end
            end
        end
    end

    // Cycle counter and log of accepted starts.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && start && start_ready) accept_log.push_back(cyc);
    end

    // ---------------- matrix helpers ----------------
    function automatic logic [N*N*DI-1:0] mat_seq();
        logic [N*N*DI-1:0] m;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                m[(i*N + k)*DI +: DI] = DI'(4*i + k + 1);
        return m;
    endfunction

    function automatic logic [N*N*DI-1:0] mat_ident(input logic [DI-1:0] d);
        logic [N*N*DI-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(i*N + i)*DI +: DI] = d;
        return m;
    endfunction

    function automatic logic [N*N*DI-1:0] mat_fill(input logic [DI-1:0] d);
        logic [N*N*DI-1:0] m;
        for (int i = 0; i < N*N; i++) m[i*DI +: DI] = d;
        return m;
    endfunction

    function automatic logic [N*N*DO-1:0] res_fill(input logic [DO-1:0] d);
        logic [N*N*DO-1:0] r;
        for (int i = 0; i < N*N; i++) r[i*DO +: DO] = d;
        return r;
    endfunction

    // Operand matrix scaled element-wise and widened to result format.
    function automatic logic [N*N*DO-1:0] expand(input logic [N*N*DI-1:0] m, input int scale);
        logic [N*N*DO-1:0] r;
        logic signed [DI-1:0] e;
        int v;
        for (int i = 0; i < N*N; i++) begin
            e = m[i*DI +: DI];
            v = int'(e) * scale;
            r[i*DO +: DO] = DO'(v);
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [N*N*DI-1:0] a, input logic [N*N*DI-1:0] b,
                           input bit accum, output int lat, output int done_cnt,
                           output bit clr_seen);
        a_mat = a;
        b_mat = b;
        start = 1'b1;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
        start_accum = accum;
`endif
        tick();
        start = 1'b0;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
        start_accum = 1'b0;
`endif
        a_mat = ~a;
        b_mat = ~b;
        lat = 1;
        done_cnt = done ? 1 : 0;
        clr_seen = !arr_rst_n;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
            if (done) done_cnt++;
            if (!arr_rst_n) clr_seen = 1'b1;
        end
    endtask

    task automatic finish_job();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (arr_rst_n !== 1'b0) begin tests_failed++; $display("FAIL reset_arr_rst_n: got %b expected 0", arr_rst_n); end
        tests_run++;
        if ({arr_a, arr_b} !== '0) begin tests_failed++; $display("FAIL reset_edges: got %h expected 0", {arr_a, arr_b}); end
        tests_run++;
        if ({res_valid, done, busy} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {res_valid, done, busy}); end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({start_ready, busy, res_valid, arr_rst_n} !== 4'b1001) begin
            tests_failed++; $display("FAIL reset_release: got %b expected 1001", {start_ready, busy, res_valid, arr_rst_n});
        end
        tests_run++;
        if (c_mat !== '0) begin tests_failed++; $display("FAIL reset_c_mat: got %h expected 0", c_mat); end
    endtask

    task automatic test_identity();
        int lat, dc;
        bit clr;
        logic [N*N*DO-1:0] exp_c;
        exp_c = expand(mat_seq(), 1);
        run_job(mat_ident(8'd1), mat_seq(), 1'b0, lat, dc, clr);
        tests_run++;
        if (lat !== 14) begin tests_failed++; $display("FAIL identity_latency: got %0d expected 14", lat); end
        tests_run++;
        if (c_mat !== exp_c) begin tests_failed++; $display("FAIL identity_c: got %h expected %h", c_mat, exp_c); end
        tests_run++;
        if (dc !== 1 || done !== 1'b1) begin tests_failed++; $display("FAIL identity_done_rise: got count %0d done %b expected 1 1", dc, done); end
        tests_run++;
        if (clr !== 1'b1) begin tests_failed++; $display("FAIL identity_clear: got %b expected 1", clr); end
        tests_run++;
        if ({busy, start_ready} !== 2'b10) begin tests_failed++; $display("FAIL identity_busy: got %b expected 10", {busy, start_ready}); end
        tick();
        tests_run++;
        if ({done, res_valid} !== 2'b01) begin tests_failed++; $display("FAIL identity_done_pulse: got %b expected 01", {done, res_valid}); end
        finish_job();
        tests_run++;
        if ({res_valid, busy, start_ready} !== 3'b001) begin
            tests_failed++; $display("FAIL identity_to_idle: got %b expected 001", {res_valid, busy, start_ready});
        end
    endtask

    task automatic test_extremes();
        int lat, dc;
        bit clr;
        run_job(mat_fill(8'h80), mat_fill(8'h80), 1'b0, lat, dc, clr);
        tests_run++;
        if (c_mat !== res_fill(18'h10000)) begin tests_failed++; $display("FAIL extremes_neg: got %h expected %h", c_mat, res_fill(18'h10000)); end
        finish_job();
        run_job(mat_fill(8'h7F), mat_fill(8'h7F), 1'b0, lat, dc, clr);
        tests_run++;
        if (c_mat !== res_fill(18'd64516)) begin tests_failed++; $display("FAIL extremes_pos: got %h expected %h", c_mat, res_fill(18'd64516)); end
        finish_job();
    endtask

    task automatic test_back_to_back();
        int base, n;
        logic [N*N*DO-1:0] exp1;
        exp1 = expand(mat_seq(), 1);
        base = accept_log.size();
        a_mat = mat_ident(8'd1);
        b_mat = mat_seq();
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        a_mat = '0;
        b_mat = '0;
        n = 0;
        while (!res_valid && n < 40) begin tick(); n++; end
        tests_run++;
        if (c_mat !== exp1) begin tests_failed++; $display("FAIL b2b_job1_c: got %h expected %h", c_mat, exp1); end
        n = 0;
        do begin tick(); n++; end while (!res_valid && n < 40);
        start = 1'b0;
        tests_run++;
        if (c_mat !== '0) begin tests_failed++; $display("FAIL b2b_job2_c: got %h expected 0", c_mat); end
        tests_run++;
        if (accept_log.size() != base + 2) begin
            tests_failed++; $display("FAIL b2b_accepts: got %0d expected 2", accept_log.size() - base);
        end else if (accept_log[base+1] - accept_log[base] != 15) begin
            tests_failed++; $display("FAIL b2b_period: got %0d expected 15", accept_log[base+1] - accept_log[base]);
        end
        tick();
        res_ready = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        int lat, dc, base;
        bit clr, stable;
        run_job(mat_fill(8'd1), mat_fill(8'd1), 1'b0, lat, dc, clr);
        tests_run++;
        if (c_mat !== res_fill(18'd4)) begin tests_failed++; $display("FAIL hold_c: got %h expected %h", c_mat, res_fill(18'd4)); end
        base = accept_log.size();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            a_mat = mat_fill(8'h7F);
            tick();
            if (c_mat !== res_fill(18'd4) || res_valid !== 1'b1 || start_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        tests_run++;
        if (stable !== 1'b1 || accept_log.size() != base) begin
            tests_failed++; $display("FAIL hold_stable: got stable %b accepts %0d expected 1 0", stable, accept_log.size() - base);
        end
        res_ready = 1'b1;
        tick();
        start = 1'b0;
        res_ready = 1'b0;
        tests_run++;
        if ({res_valid, start_ready, busy} !== 3'b010 || accept_log.size() != base) begin
            tests_failed++; $display("FAIL hold_handshake: got %b accepts %0d expected 010 0", {res_valid, start_ready, busy}, accept_log.size() - base);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL hold_no_queue: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_feed();
        int lat, dc;
        bit clr;
        logic [N*N*DO-1:0] exp_c;
        a_mat = mat_seq();
        b_mat = mat_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        tests_run++;
        if (arr_a !== {8'd13, 8'd10, 8'd7, 8'd4}) begin tests_failed++; $display("FAIL skew_a_step3: got %h expected 0d0a0704", arr_a); end
        tests_run++;
        if (arr_b !== {8'd4, 8'd7, 8'd10, 8'd13}) begin tests_failed++; $display("FAIL skew_b_step3: got %h expected 04070a0d", arr_b); end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({arr_rst_n, busy, res_valid, start_ready} !== 4'b0001 || {arr_a, arr_b} !== '0) begin
            tests_failed++; $display("FAIL midfeed_reset: got %b edges %h expected 0001 0", {arr_rst_n, busy, res_valid, start_ready}, {arr_a, arr_b});
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_c = expand(mat_seq(), -1);
        run_job(mat_ident(8'hFF), mat_seq(), 1'b0, lat, dc, clr);
        tests_run++;
        if (c_mat !== exp_c || lat !== 14) begin
            tests_failed++; $display("FAIL midfeed_rerun: got %h lat %0d expected %h lat 14", c_mat, lat, exp_c);
        end
        finish_job();
    endtask

`ifdef SYSTOLIC_SEQ_ACCUM_EN
    task automatic test_accum();
        int lat, dc;
        bit clr;
        logic [N*N*DO-1:0] exp1, exp2;
        exp1 = expand(mat_ident(8'd1), 1);
        exp2 = expand(mat_ident(8'd1), 2);
        run_job(mat_ident(8'd1), mat_ident(8'd1), 1'b0, lat, dc, clr);
        tests_run++;
        if (c_mat !== exp1 || lat !== 14) begin tests_failed++; $display("FAIL accum_job1: got %h lat %0d expected %h lat 14", c_mat, lat, exp1); end
        finish_job();
        run_job(mat_ident(8'd1), mat_ident(8'd1), 1'b1, lat, dc, clr);
        tests_run++;
        if (c_mat !== exp2) begin tests_failed++; $display("FAIL accum_job2_c: got %h expected %h", c_mat, exp2); end
        tests_run++;
        if (lat !== 13 || clr !== 1'b0) begin tests_failed++; $display("FAIL accum_job2_flow: got lat %0d clear %b expected 13 0", lat, clr); end
        finish_job();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_identity();
        test_extremes();
        test_back_to_back();
        test_hold();
        test_reset_mid_feed();
`ifdef SYSTOLIC_SEQ_ACCUM_EN
        test_accum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
